// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// UART_ARB_ID_HEADER_EN adds the HEADER state that prefixes each packet with its port ID.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
`ifdef UART_ARB_ID_HEADER_EN
        HEADER = 2'b01,
`endif
        PASS   = 2'b10
    } state_t;

    localparam int unsigned ID_HDR_WIDTH = 8;

    // Index width for n ports; a single bit is kept even when $clog2 would give 0.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first request at or after ptr_i wins.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    assign any_o = |req_i;

    // Scan from the farthest offset down to offset 0 so the nearest request overwrites the rest.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        cand   = '0;
        for (int unsigned k = N; k > 0; k--) begin
            cand = IW'((32'(ptr_i) + k - 32'd1) % N);
            if (req_i[cand]) begin
                pick_o       = '0;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one AXI4-Stream UART transmitter.
// Define UART_ARB_ID_HEADER_EN to prefix every packet with the granted port index.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy
);

    localparam int unsigned IW = idx_width(NUM_PORTS);

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0]   pick;
    logic [IW-1:0]          pick_idx;
    logic                   any_req;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_valid;
    logic                   sel_last;

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_rr_pick (
        .req_i  (s_axis_tvalid),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (any_req)
    );

    assign sel_data  = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid = s_axis_tvalid[gidx_q];
    assign sel_last  = s_axis_tlast[gidx_q];
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
`ifdef UART_ARB_ID_HEADER_EN
                    state_d = HEADER;
`else
                    state_d = PASS;
`endif
                end
            end
`ifdef UART_ARB_ID_HEADER_EN
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(ID_HDR_WIDTH'(gidx_q));
                if (m_axis_tready) begin
                    state_d = PASS;
                end
            end
`endif
            PASS: begin
                m_axis_tdata  = sel_data;
                m_axis_tvalid = sel_valid;
                s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
                // Only the owner's tlast handshake releases the lock; idle gaps keep it.
                if (sel_valid && m_axis_tready && sel_last) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == IW'(NUM_PORTS - 1)) ? '0 : gidx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 ports, 8-bit beats).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        arst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [3:0]  grant;
    logic        busy;

    uart_tx_arbiter #(
        .NUM_PORTS  (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] srcq [4][$];
    logic [7:0] obytes[$];
    logic [7:0] ebytes[$];
    int         glog[$];
    int         eglog[$];
    logic [3:0] gate = 4'hF;
    bit         tog  = 1'b0;
    logic [3:0] prev_grant = 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int p = 0; p < 4; p++) if (srcq[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic ld(input int p, input logic [7:0] d, input logic l);
        srcq[p].push_back({l, d});
    endtask

    task automatic exh(input int p);
`ifdef UART_ARB_ID_HEADER_EN
        ebytes.push_back(8'(p));
`endif
        eglog.push_back(p);
    endtask

    // One cycle: present source heads at negedge, then sample and account for handshakes.
    task automatic cyc();
        logic [8:0] head;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (gate[p] && srcq[p].size() > 0) begin
                head = srcq[p][0];
                s_axis_tvalid[p]       = 1'b1;
                s_axis_tdata[p*8 +: 8] = head[7:0];
                s_axis_tlast[p]        = head[8];
            end else begin
                s_axis_tvalid[p]       = 1'b0;
                s_axis_tdata[p*8 +: 8] = 8'h00;
                s_axis_tlast[p]        = 1'b0;
            end
        end
        m_axis_tready = tog ? ~m_axis_tready : 1'b1;
        #1;
        check("tready_outside_grant", 32'(s_axis_tready & ~grant), 32'h0);
        check("grant_onehot", 32'(grant & (grant - 4'd1)), 32'h0);
        if (m_axis_tvalid && m_axis_tready) obytes.push_back(m_axis_tdata);
        for (int p = 0; p < 4; p++)
            if (s_axis_tvalid[p] && s_axis_tready[p]) void'(srcq[p].pop_front());
        if (grant != 4'h0 && grant != prev_grant) glog.push_back(oh2i(grant));
        prev_grant = grant;
    endtask

    task automatic cmp_logs(input string tag);
        check({tag, "_nbytes"}, 32'(obytes.size()), 32'(ebytes.size()));
        for (int i = 0; i < ebytes.size() && i < obytes.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(obytes[i]), 32'(ebytes[i]));
        check({tag, "_ngrants"}, 32'(glog.size()), 32'(eglog.size()));
        for (int i = 0; i < eglog.size() && i < glog.size(); i++)
            check($sformatf("%s_grant%0d", tag, i), 32'(glog[i]), 32'(eglog[i]));
        obytes.delete(); ebytes.delete(); glog.delete(); eglog.delete();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!(all_empty() && !busy) && n < budget);
        check({tag, "_drained"}, 32'(all_empty() && !busy), 32'h1);
        check({tag, "_idle_grant"}, 32'(grant), 32'h0);
        cmp_logs(tag);
    endtask

    initial begin
        arst          = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_sready", 32'(s_axis_tready), 32'h0);
        arst = 1'b0;

        // Fairness: all ports busy, grants rotate 0,1,2,3,0,1.
        ld(0, 8'hA0, 0); ld(0, 8'hA1, 1); ld(0, 8'hA2, 0); ld(0, 8'hA3, 1);
        ld(1, 8'hB0, 0); ld(1, 8'hB1, 1); ld(1, 8'hB2, 0); ld(1, 8'hB3, 1);
        ld(2, 8'hC0, 0); ld(2, 8'hC1, 1);
        ld(3, 8'hD0, 0); ld(3, 8'hD1, 1);
        exh(0); ebytes.push_back(8'hA0); ebytes.push_back(8'hA1);
        exh(1); ebytes.push_back(8'hB0); ebytes.push_back(8'hB1);
        exh(2); ebytes.push_back(8'hC0); ebytes.push_back(8'hC1);
        exh(3); ebytes.push_back(8'hD0); ebytes.push_back(8'hD1);
        exh(0); ebytes.push_back(8'hA2); ebytes.push_back(8'hA3);
        exh(1); ebytes.push_back(8'hB2); ebytes.push_back(8'hB3);
        run_until_idle("fair", 200);

        // Single port 1 packet; rr_ptr ends at 2.
        ld(1, 8'h41, 0); ld(1, 8'h42, 0); ld(1, 8'h43, 1);
        exh(1); ebytes.push_back(8'h41); ebytes.push_back(8'h42); ebytes.push_back(8'h43);
        run_until_idle("single", 50);

        // rr_ptr=2: port 2 beats port 1, leaving rr_ptr=2 again.
        ld(1, 8'h61, 1); ld(2, 8'h62, 1);
        exh(2); ebytes.push_back(8'h62);
        exh(1); ebytes.push_back(8'h61);
        run_until_idle("ptr2", 50);

        // One-beat packet from port 2 (ID header 0x02 when enabled); rr_ptr becomes 3.
        ld(2, 8'h55, 1);
        exh(2); ebytes.push_back(8'h55);
        run_until_idle("hdr", 50);

        // Wrap from rr_ptr=3: port 0 before port 2.
        ld(0, 8'h70, 1); ld(2, 8'h72, 1);
        exh(0); ebytes.push_back(8'h70);
        exh(2); ebytes.push_back(8'h72);
        run_until_idle("wrap", 50);

        // Lock: port 0 stalls mid-packet while port 3 requests, ready toggling.
        tog = 1'b1;
        ld(0, 8'hE0, 0); ld(0, 8'hE1, 0); ld(0, 8'hE2, 1);
        begin
            int n = 0;
            while (srcq[0].size() != 2 && n < 20) begin
                cyc();
                n++;
            end
            check("lock_first_beat", 32'(srcq[0].size()), 32'd2);
        end
        gate[0] = 1'b0;
        ld(3, 8'hF0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("lock_hold%0d", i), 32'(grant), 32'h1);
        end
        gate[0] = 1'b1;
        exh(0); ebytes.push_back(8'hE0); ebytes.push_back(8'hE1); ebytes.push_back(8'hE2);
        exh(3); ebytes.push_back(8'hF0);
        run_until_idle("lock", 100);
        tog = 1'b0;

        // Async reset mid-packet, then search restarts from port 0.
        for (int i = 0; i < 5; i++) ld(1, 8'h90 + 8'(i), (i == 4));
        repeat (3) cyc();
        check("rst_pre_busy", 32'(busy), 32'h1);
        @(negedge clk);
        #2 arst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_mvalid", 32'(m_axis_tvalid), 32'h0);
        check("arst_sready", 32'(s_axis_tready), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst          = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        for (int p = 0; p < 4; p++) srcq[p].delete();
        obytes.delete(); glog.delete(); prev_grant = 4'h0;
        ld(1, 8'h81, 1); ld(2, 8'h82, 1);
        cyc();
        check("postrst_idle_busy", 32'(busy), 32'h0);
        check("postrst_idle_sready", 32'(s_axis_tready), 32'h0);
        cyc();
        check("postrst_grant", 32'(grant), 32'h2);
        check("postrst_busy", 32'(busy), 32'h1);
        exh(1); ebytes.push_back(8'h81);
        exh(2); ebytes.push_back(8'h82);
        run_until_idle("postrst", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one AXI4-Stream UART transmitter between NUM_PORTS byte-stream requesters.
- Arbitration is round-robin with a packet lock: a granted port keeps the transmitter until its tlast beat completes.
- Sits between the host-side producers (spike/status/debug streams) and the s_axis input of the UART transceiver.
- Output is byte-serialised, so packets from different ports never interleave on txd.

Parameters:
- NUM_PORTS, 4, number of requester ports; 2..16 supported.
- DATA_WIDTH, 8, beat width; must match the UART transceiver DATA_WIDTH.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tlast  in  NUM_PORTS  per-port end-of-packet
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  DATA_WIDTH  to UART s_axis_tdata
- m_axis_tvalid  out  1  to UART s_axis_tvalid
- m_axis_tready  in  1  from UART s_axis_tready
- grant  out  NUM_PORTS  one-hot current owner; all-zero when idle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (async on arst high): state=IDLE; grant=0; rr_ptr=0; m_axis_tvalid=0; s_axis_tready=0; busy=0. m_axis_tdata is don't-care while tvalid=0.
- States: IDLE, HEADER (only with the optional feature), PASS.
- IDLE:
  - If any s_axis_tvalid is high, pick the first valid port searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Register the one-hot grant and go to PASS, or to HEADER when the feature is enabled.
  - Arbitration costs exactly one idle cycle; no beat is accepted in IDLE.
- PASS (combinational pass-through for granted port g):
  - m_axis_tdata = port g data; m_axis_tvalid = s_axis_tvalid[g]; s_axis_tready[g] = m_axis_tready.
  - All other s_axis_tready are 0.
  - A handshake is m_axis_tvalid && m_axis_tready.
  - On a handshake with s_axis_tlast[g]=1: next state IDLE, grant cleared, rr_ptr = (g+1) mod NUM_PORTS.
  - Handshakes without tlast keep the lock, even if the owner drops tvalid for any number of cycles.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,3,0,...
- A port whose tvalid rises while another port holds the lock waits; it is not pre-empted.
- tvalid toggling on a non-granted port has no effect and must not disturb grant.
- Reset mid-packet: the packet is abandoned, there is no flush, and the next grant starts the search from port 0.
- The arbiter never drops or duplicates a beat. AXI rule: m_axis_tvalid, once asserted, is not withdrawn by the arbiter before its handshake.
- Width rules: rr_ptr and the grant index are $clog2(NUM_PORTS) bits; the pointer wraps NUM_PORTS-1 -> 0.

Optional Feature:
- Macro: UART_ARB_ID_HEADER_EN.
- Enabled:
  - After a grant, state HEADER drives m_axis_tvalid=1, m_axis_tdata = granted index zero-extended to DATA_WIDTH, all s_axis_tready=0.
  - On m_axis_tready go to PASS.
  - Each packet is prefixed with exactly one ID byte, letting the host demultiplex.
- Disabled: HEADER state and logic are absent; IDLE goes straight to PASS and output bytes are the payload only.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding constants IDLE=2'b00, HEADER=2'b01, PASS=2'b10;
  - a function for the index width ($clog2 with a minimum of 1);
  - the ID header width constant.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot pick, binary index, any_req.
  - Reused by future arbiters in the codebase.

Test Plan:
- Reset: assert arst for 3 cycles during an active packet -> grant=0, busy=0, m_axis_tvalid=0 immediately (async); after release, port 2 requesting alone is granted after 1 idle cycle.
- Single port: port 1 sends 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready held high -> m_axis_tdata sequence 0x41,0x42,0x43; then IDLE and rr_ptr=2.
- Fairness: all 4 ports send 2-byte packets continuously -> grant order 0,1,2,3,0,1; no interleaving within any packet.
- Lock/backpressure: port 0 mid-packet drops tvalid for 10 cycles while port 3 requests, m_axis_tready toggling 1/0 -> grant stays on port 0 until its tlast handshake; bytes preserved in order.
- Wrap: rr_ptr=3 with ports 0 and 2 requesting -> port 0 granted first, then port 2.
- With UART_ARB_ID_HEADER_EN: port 2 sends 0x55 (tlast) -> output 0x02,0x55; without the macro -> output 0x55 only.
